// File: rtl/ps_pkg.sv
// ============================================================================
// Module      : ps_pkg
// Description : Shared constants for the pixel-stream Gaussian MAC.
// Revision    : 1.0
// ============================================================================
`default_nettype none

package ps_pkg;
  localparam int unsigned GAUSS_W_EDGE     = 1;
  localparam int unsigned GAUSS_W_MID      = 2;
  localparam int unsigned GAUSS_W_CTR      = 4;
  localparam int unsigned GAUSS_NORM_SHIFT = 4;
  localparam int unsigned GAUSS_ROUND      = 8;
  localparam int unsigned PS_MAC_LATENCY   = 3;
endpackage

`default_nettype wire

// File: rtl/ps_row_mac.sv
// ============================================================================
// Module      : ps_row_mac
// Description : One window row, registered p0 + 2*p1 + p2 (p1 = centre slot).
// Revision    : 1.0
// ============================================================================
`default_nettype none

module ps_row_mac
  import ps_pkg::*;
#(
  parameter int DATA_WIDTH = 8
) (
  input  logic                      i_clk,
  input  logic                      i_rstn,
  input  logic [3*DATA_WIDTH-1:0]   i_row,
  output logic [DATA_WIDTH+1:0]     o_sum
);

  localparam int c_sw = DATA_WIDTH + 2;
  localparam logic [c_sw-1:0] c_w_edge = c_sw'(GAUSS_W_EDGE);
  localparam logic [c_sw-1:0] c_w_mid  = c_sw'(GAUSS_W_MID);

  logic [c_sw-1:0] w_p0;
  logic [c_sw-1:0] w_p1;
  logic [c_sw-1:0] w_p2;
  logic [c_sw-1:0] w_sum;
  logic [c_sw-1:0] r_sum;

  assign w_p0  = c_sw'(i_row[0            +: DATA_WIDTH]);
  assign w_p1  = c_sw'(i_row[DATA_WIDTH   +: DATA_WIDTH]);
  assign w_p2  = c_sw'(i_row[2*DATA_WIDTH +: DATA_WIDTH]);
  assign w_sum = c_w_edge * w_p0 + c_w_mid * w_p1 + c_w_edge * w_p2;

  // Loads every cycle; the valid chain in the parent decides what is meaningful.
  always_ff @(posedge i_clk or negedge i_rstn) begin
    if (!i_rstn) begin
      r_sum <= '0;
    end else begin
      r_sum <= w_sum;
    end
  end

  assign o_sum = r_sum;

endmodule

`default_nettype wire

// File: rtl/ps_gaussian_mac.sv
// ============================================================================
// Module      : ps_gaussian_mac
// Description : 3-stage 3x3 Gaussian blur MAC with EOL/EOF tagging.
//               Optional PS_GAUSS_BINARIZE_EN adds i_threshold and binarizes.
// Revision    : 1.0
// ============================================================================
`default_nettype none

module ps_gaussian_mac
  import ps_pkg::*;
#(
  parameter int DATA_WIDTH  = 8,
  parameter int LINE_LENGTH = 640,
  parameter int LINE_COUNT  = 480
) (
  input  logic                    i_clk,
  input  logic                    i_rstn,
  input  logic [3*DATA_WIDTH-1:0] i_r0_data,
  input  logic [3*DATA_WIDTH-1:0] i_r1_data,
  input  logic [3*DATA_WIDTH-1:0] i_r2_data,
  input  logic                    i_valid,
`ifdef PS_GAUSS_BINARIZE_EN
  input  logic [DATA_WIDTH-1:0]   i_threshold,
`endif
  output logic [DATA_WIDTH-1:0]   o_data,
  output logic                    o_valid,
  output logic                    o_eol,
  output logic                    o_eof
);

  localparam int c_sw   = DATA_WIDTH + 2;
  localparam int c_aw   = DATA_WIDTH + 4;
  localparam int c_cw   = $clog2(LINE_LENGTH > 1 ? LINE_LENGTH : 2);
  localparam int c_lw   = $clog2(LINE_COUNT > 1 ? LINE_COUNT : 2);
  localparam int c_vlen = PS_MAC_LATENCY - 1;

  localparam logic [c_aw-1:0] c_w_outer  = c_aw'(GAUSS_W_EDGE);
  localparam logic [c_aw-1:0] c_w_centre = c_aw'(GAUSS_W_CTR / GAUSS_W_MID);
  localparam logic [c_aw-1:0] c_round    = c_aw'(GAUSS_ROUND);
  localparam logic [c_cw-1:0] c_col_last = c_cw'(LINE_LENGTH - 1);
  localparam logic [c_lw-1:0] c_line_last = c_lw'(LINE_COUNT - 1);

  logic [3*DATA_WIDTH-1:0] w_row_in  [3];
  logic [c_sw-1:0]         w_row_sum [3];

  assign w_row_in[0] = i_r0_data;
  assign w_row_in[1] = i_r1_data;
  assign w_row_in[2] = i_r2_data;

  // Stage 1: horizontal 1-2-1 per row
  for (genvar g = 0; g < 3; g++) begin : g_row
    ps_row_mac #(
      .DATA_WIDTH (DATA_WIDTH)
    ) u_row_mac (
      .i_clk  (i_clk),
      .i_rstn (i_rstn),
      .i_row  (w_row_in[g]),
      .o_sum  (w_row_sum[g])
    );
  end

  logic [c_vlen-1:0]     r_vld;
  logic [c_aw-1:0]       r_acc;
  logic [DATA_WIDTH-1:0] r_data;
  logic                  r_valid;
  logic                  r_eol;
  logic                  r_eof;
  logic [c_cw-1:0]       r_col;
  logic [c_lw-1:0]       r_line;

  logic [DATA_WIDTH-1:0] w_pix;
  logic [DATA_WIDTH-1:0] w_out;
  logic                  w_s2_vld;
  logic                  w_col_end;
  logic                  w_line_end;

  assign w_s2_vld   = r_vld[c_vlen-1];
  assign w_col_end  = (r_col == c_col_last);
  assign w_line_end = (r_line == c_line_last);
  // Max acc + round still fits c_aw bits, so the shifted value fits DATA_WIDTH.
  assign w_pix      = DATA_WIDTH'((r_acc + c_round) >> GAUSS_NORM_SHIFT);

`ifdef PS_GAUSS_BINARIZE_EN
  assign w_out = (w_pix >= i_threshold) ? {DATA_WIDTH{1'b1}} : '0;
`else
  assign w_out = w_pix;
`endif

  always_ff @(posedge i_clk or negedge i_rstn) begin
    if (!i_rstn) begin
      r_vld   <= '0;
      r_acc   <= '0;
      r_data  <= '0;
      r_valid <= 1'b0;
      r_eol   <= 1'b0;
      r_eof   <= 1'b0;
      r_col   <= '0;
      r_line  <= '0;
    end else begin
      r_vld   <= c_vlen'({r_vld, i_valid});
      // Stage 2: vertical 1-2-1 over the row sums
      r_acc   <= c_w_outer * c_aw'(w_row_sum[0]) + c_w_centre * c_aw'(w_row_sum[1])
               + c_w_outer * c_aw'(w_row_sum[2]);
      // Stage 3: normalise, tag, advance position counters
      r_valid <= w_s2_vld;
      r_eol   <= w_s2_vld & w_col_end;
      r_eof   <= w_s2_vld & w_col_end & w_line_end;
      if (w_s2_vld) begin
        r_data <= w_out;
        if (w_col_end) begin
          r_col  <= '0;
          r_line <= w_line_end ? '0 : r_line + c_lw'(1);
        end else begin
          r_col  <= r_col + c_cw'(1);
        end
      end
    end
  end

  assign o_data  = r_data;
  assign o_valid = r_valid;
  assign o_eol   = r_eol;
  assign o_eof   = r_eof;

endmodule

`default_nettype wire

// File: tb/tb_ps_gaussian_mac.sv
// ============================================================================
// Module      : tb_ps_gaussian_mac
// Description : Randomized self-checking bench for ps_gaussian_mac (LL=4, LC=3).
// Revision    : 1.0
// ============================================================================
`default_nettype none

module tb_ps_gaussian_mac;

  localparam int DW = 8;
  localparam int LL = 4;
  localparam int LC = 3;

  typedef struct {
    int unsigned due;
    int unsigned data;
    bit          eol;
    bit          eof;
  } exp_t;

  logic            clk = 1'b0;
  logic            rstn = 1'b0;
  logic [3*DW-1:0] r0 = '0, r1 = '0, r2 = '0;
  logic            vin = 1'b0;
  logic [DW-1:0]   o_data;
  logic            o_valid, o_eol, o_eof;
`ifdef PS_GAUSS_BINARIZE_EN
  logic [DW-1:0]   thr = '0;
`endif

  ps_gaussian_mac #(
    .DATA_WIDTH  (DW),
    .LINE_LENGTH (LL),
    .LINE_COUNT  (LC)
  ) u_dut (
    .i_clk       (clk),
    .i_rstn      (rstn),
    .i_r0_data   (r0),
    .i_r1_data   (r1),
    .i_r2_data   (r2),
    .i_valid     (vin),
`ifdef PS_GAUSS_BINARIZE_EN
    .i_threshold (thr),
`endif
    .o_data      (o_data),
    .o_valid     (o_valid),
    .o_eol       (o_eol),
    .o_eof       (o_eof)
  );

  always #5 clk = ~clk;

  int unsigned cyc = 0;
  always @(posedge clk) cyc++;

  int   n_chk = 0;
  int   n_fail = 0;
  int   eol_cnt = 0;
  int   eof_cnt = 0;
  int   pix_cnt = 0;
  exp_t q[$];
  logic [DW-1:0] win [3][3];

  task automatic chk(input string tag, input int unsigned got, input int unsigned exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s got=%0d exp=%0d (t=%0t)", tag, got, exp, $time);
    end
  endtask

  // Final output value expected for a known rounded Gaussian result.
  function automatic int unsigned post(input int unsigned g);
`ifdef PS_GAUSS_BINARIZE_EN
    return (g >= thr) ? 255 : 0;
`else
    return g;
`endif
  endfunction

  function automatic int unsigned gauss_ref();
    int unsigned acc = 0;
    for (int r = 0; r < 3; r++)
      for (int c = 0; c < 3; c++)
        acc += win[r][c] * ((r == 1) ? 2 : 1) * ((c == 1) ? 2 : 1);
    return (acc + 8) / 16;
  endfunction

  // exp_fix < 0: expected value from the reference model; otherwise a fixed constant.
  task automatic push_win(input int exp_fix);
    exp_t e;
    r0 = {win[0][2], win[0][1], win[0][0]};
    r1 = {win[1][2], win[1][1], win[1][0]};
    r2 = {win[2][2], win[2][1], win[2][0]};
    vin = 1'b1;
    e.due  = cyc + 3;
    e.data = post((exp_fix < 0) ? gauss_ref() : int'(exp_fix));
    e.eol  = (pix_cnt % LL) == LL - 1;
    e.eof  = (pix_cnt % (LL * LC)) == LL * LC - 1;
    pix_cnt++;
    q.push_back(e);
    @(posedge clk); #1;
    vin = 1'b0;
    r0 = 24'($urandom); r1 = 24'($urandom); r2 = 24'($urandom);
  endtask

  task automatic idle(input int n);
    repeat (n) begin @(posedge clk); #1; end
  endtask

  task automatic fill(input int v);
    for (int r = 0; r < 3; r++)
      for (int c = 0; c < 3; c++)
        win[r][c] = DW'(v);
  endtask

  task automatic fill_rand();
    for (int r = 0; r < 3; r++)
      for (int c = 0; c < 3; c++)
        win[r][c] = ($urandom_range(0, 3) == 0) ? 8'(255 * $urandom_range(0, 1)) : 8'($urandom);
  endtask

  task automatic do_reset();
    rstn = 1'b0;
    q.delete();
    pix_cnt = 0;
    idle(2);
    rstn = 1'b1;
    idle(1);
  endtask

  always @(negedge clk) begin
    if (q.size() > 0 && q[0].due == cyc) begin
      chk("out_valid", o_valid, 1);
      chk("out_data", o_data, q[0].data);
      chk("out_eol", o_eol, q[0].eol);
      chk("out_eof", o_eof, q[0].eof);
      if (o_valid && o_eol) eol_cnt++;
      if (o_valid && o_eof) eof_cnt++;
      void'(q.pop_front());
    end else begin
      chk("idle_valid", o_valid, 0);
      chk("idle_eol", o_eol, 0);
      chk("idle_eof", o_eof, 0);
    end
  end

  initial begin
    #1;
    chk("rst_data", o_data, 0);
    chk("rst_valid", o_valid, 0);
    chk("rst_eol", o_eol, 0);
    chk("rst_eof", o_eof, 0);
    idle(2);
    rstn = 1'b1;
    idle(2);

    // Flat field, single window, then isolated impulses
    fill(100);         push_win(100); idle(5);
    fill(0); win[1][1] = 255; push_win(64);  idle(2);
    fill(0); win[0][0] = 255; push_win(16);  idle(2);
    fill(0); win[2][2] = 255; push_win(16);  idle(2);
    fill(255);         push_win(255); idle(4);

    // Back-to-back then random gaps
    for (int i = 0; i < 8; i++) begin fill_rand(); push_win(-1); end
    for (int i = 0; i < 30; i++) begin
      fill_rand(); push_win(-1);
      idle($urandom_range(1, 3));
    end
    idle(4);

    // Two full frames of tags
    do_reset();
    eol_cnt = 0; eof_cnt = 0;
    for (int i = 0; i < 24; i++) begin
      fill_rand(); push_win(-1);
      idle($urandom_range(0, 2));
    end
    idle(5);
    chk("eol_count", eol_cnt, 6);
    chk("eof_count", eof_cnt, 2);

    // Reset mid-line with two windows in flight
    fill_rand(); push_win(-1);
    idle(3);
    fill_rand(); push_win(-1);
    fill_rand(); push_win(-1);
    rstn = 1'b0;
    q.delete();
    pix_cnt = 0;
    #1;
    chk("midrst_valid", o_valid, 0);
    chk("midrst_data", o_data, 0);
    chk("midrst_eol", o_eol, 0);
    idle(2);
    rstn = 1'b1;
    idle(5);
    for (int i = 0; i < 6; i++) begin fill_rand(); push_win(-1); end
    idle(5);

`ifdef PS_GAUSS_BINARIZE_EN
    thr = 8'd64;
    fill(0); win[1][1] = 255; push_win(64); idle(2);
    fill(0); win[0][2] = 255; push_win(16); idle(4);
    for (int i = 0; i < 10; i++) begin fill_rand(); push_win(-1); end
    idle(4);
    thr = 8'd0;
    for (int i = 0; i < 10; i++) begin fill_rand(); push_win(-1); end
    idle(4);
`endif

    chk("queue_drained", q.size(), 0);
    $display("TB_RESULT checks=%0d failures=%0d", n_chk, n_fail);
    $finish;
  end

endmodule

`default_nettype wire
